// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: RV32I 5-stage pipeline control unit.
// Decodes in D, carries control through the D/E, E/M and M/W registers,
// and resolves branch/jump redirection in E.
module rv_pipe_ctrl #(
  parameter bit EN_FULL_BRANCH = 1'b1,
  parameter bit EN_SHIFT       = 1'b1,
  parameter bit EN_UTYPE       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opD,
  input  logic [2:0] funct3D,
  input  logic       funct7b5D,
  input  logic       FlushE,
  input  logic       Hold,
  input  logic       ZeroE,
  input  logic       LtE,
  input  logic       LtuE,
  output logic [2:0] ImmSrcD,
  output logic       IllegalD,
  output logic [3:0] ALUControlE,
  output logic [1:0] ALUSrcAE,
  output logic       ALUSrcBE,
  output logic       PCSrcE,
  output logic       PCTargetSrcE,
  output logic       ResultSrcE0,
  output logic       RegWriteE,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic       MemWriteM,
  output logic [2:0] funct3M,
  output logic [1:0] ResultSrcW,
  output logic       IllegalE
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_FUNC = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       reg_w;
    logic [1:0] res_src;
    logic       mem_w;
    logic       jump;
    logic       branch;
    logic       jalr;
    alu_ctrl_e  alu_ctrl;
    logic [1:0] src_a;
    logic       src_b;
    logic [2:0] funct3;
    logic       illegal;
  } de_t;

  typedef struct packed {
    logic       reg_w;
    logic [1:0] res_src;
    logic       mem_w;
    logic [2:0] funct3;
  } em_t;

  typedef struct packed {
    logic       reg_w;
    logic [1:0] res_src;
  } mw_t;

  de_t       de_d, de_q;
  em_t       em_d, em_q;
  mw_t       mw_d, mw_q;
  alu_op_e   alu_op;
  alu_ctrl_e alu_ctrl;
  logic      reg_w, mem_w, branch, jump, jalr, src_b, illegal, taken;
  logic [1:0] src_a, res_src;
  logic [2:0] imm_src;

  // Main decoder: raw controls and legality of the instruction in D.
  always_comb begin
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    jalr    = 1'b0;
    imm_src = 3'b000;
    src_a   = 2'b00;
    src_b   = 1'b0;
    res_src = 2'b00;
    alu_op  = OP_ADD;
    illegal = 1'b0;
    unique case (opD)
      7'b0000011: begin reg_w = 1'b1; src_b = 1'b1; res_src = 2'b01; end
      7'b0100011: begin mem_w = 1'b1; imm_src = 3'b001; src_b = 1'b1; end
      7'b0110011, 7'b0010011: begin
        reg_w  = 1'b1;
        src_b  = (opD == 7'b0010011);
        alu_op = OP_FUNC;
        if (!EN_SHIFT && (funct3D == 3'b001 || funct3D == 3'b101)) illegal = 1'b1;
      end
      7'b1100011: begin
        branch  = 1'b1;
        imm_src = 3'b010;
        alu_op  = OP_SUB;
        if (funct3D == 3'b010 || funct3D == 3'b011) illegal = 1'b1;
        if (!EN_FULL_BRANCH && funct3D[2]) illegal = 1'b1;
      end
      7'b1101111: begin reg_w = 1'b1; jump = 1'b1; imm_src = 3'b011; res_src = 2'b10; end
      7'b1100111: begin
        reg_w = 1'b1; jump = 1'b1; jalr = 1'b1; src_b = 1'b1; res_src = 2'b10;
        if (funct3D != 3'b000) illegal = 1'b1;
      end
      7'b0110111: begin
        reg_w = 1'b1; imm_src = 3'b100; src_a = 2'b10; src_b = 1'b1;
        if (!EN_UTYPE) illegal = 1'b1;
      end
      7'b0010111: begin
        reg_w = 1'b1; imm_src = 3'b100; src_a = 2'b01; src_b = 1'b1;
        if (!EN_UTYPE) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // ALU decoder: ALUOp plus funct3/funct7b5 to ALU operation code.
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      OP_SUB:  alu_ctrl = ALU_SUB;
      OP_FUNC: begin
        unique case (funct3D)
          3'b000:  alu_ctrl = (opD == 7'b0110011 && funct7b5D) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5D ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // Assemble D/E payload; an illegal instruction carries no side effects.
  always_comb begin
    de_d          = '0;
    de_d.reg_w    = reg_w  & ~illegal;
    de_d.mem_w    = mem_w  & ~illegal;
    de_d.branch   = branch & ~illegal;
    de_d.jump     = jump   & ~illegal;
    de_d.jalr     = jalr   & ~illegal;
    de_d.res_src  = res_src;
    de_d.alu_ctrl = alu_ctrl;
    de_d.src_a    = src_a;
    de_d.src_b    = src_b;
    de_d.funct3   = funct3D;
    de_d.illegal  = illegal;
  end

  // D/E register: reset, then Hold (flush not latched), then flush, then load.
  always_ff @(posedge clk) begin
    if (reset)       de_q <= '0;
    else if (!Hold)  de_q <= FlushE ? '0 : de_d;
  end

  // E/M and M/W next-state: plain forward shift.
  always_comb begin
    em_d         = '0;
    em_d.reg_w   = de_q.reg_w;
    em_d.res_src = de_q.res_src;
    em_d.mem_w   = de_q.mem_w;
    em_d.funct3  = de_q.funct3;
    mw_d         = '0;
    mw_d.reg_w   = em_q.reg_w;
    mw_d.res_src = em_q.res_src;
  end

  // E/M and M/W registers: reset clears, Hold freezes.
  always_ff @(posedge clk) begin
    if (reset) begin
      em_q <= '0;
      mw_q <= '0;
    end else if (!Hold) begin
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // Branch condition by funct3 in E.
  always_comb begin
    taken = 1'b0;
    unique case (de_q.funct3)
      3'b000:  taken = ZeroE;
      3'b001:  taken = ~ZeroE;
      3'b100:  taken = LtE;
      3'b101:  taken = ~LtE;
      3'b110:  taken = LtuE;
      3'b111:  taken = ~LtuE;
      default: taken = 1'b0;
    endcase
  end

  assign ImmSrcD      = imm_src;
  assign IllegalD     = illegal;
  assign ALUControlE  = de_q.alu_ctrl;
  assign ALUSrcAE     = de_q.src_a;
  assign ALUSrcBE     = de_q.src_b;
  assign PCSrcE       = ((de_q.branch & taken) | de_q.jump) & ~Hold;
  assign PCTargetSrcE = de_q.jalr;
  assign ResultSrcE0  = de_q.res_src[0];
  assign RegWriteE    = de_q.reg_w;
  assign IllegalE     = de_q.illegal;
  assign RegWriteM    = em_q.reg_w;
  assign MemWriteM    = em_q.mem_w;
  assign funct3M      = em_q.funct3;
  assign RegWriteW    = mw_q.reg_w;
  assign ResultSrcW   = mw_q.res_src;

endmodule

// File: doc/rv_pipe_ctrl.md
Name: rv_pipe_ctrl

Overview:
- Next-generation pipelined control unit for the RV32I 5-stage core.
- Decodes the instruction in D, then carries control through the D/E, E/M and M/W control registers.
- Resolves full-RV32I branch and jump redirection in E, with flush and hold handling and illegal-instruction detection.
- Feeds the datapath and the hazard unit.

Parameters:
- EN_FULL_BRANCH, 1: 1 = BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 = BEQ/BNE only, other branch funct3 values are illegal.
- EN_SHIFT, 1: 1 = SLL/SRL/SRA (R and I forms); 0 = shift funct3 values are illegal.
- EN_UTYPE, 1: 1 = LUI/AUIPC decoded; 0 = those opcodes are illegal.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- opD  in  7  opcode in D.
- funct3D  in  3  funct3 in D.
- funct7b5D  in  1  instr[30] in D.
- FlushE  in  1  from hazard unit: load a bubble into D/E.
- Hold  in  1  freeze D/E, E/M and M/W control registers (memory wait).
- ZeroE  in  1  ALU result == 0.
- LtE  in  1  signed rs1 < rs2.
- LtuE  in  1  unsigned rs1 < rs2.
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- IllegalD  out  1  combinational: unsupported encoding in D.
- ALUControlE  out  4  ALU operation code.
- ALUSrcAE  out  2  00 rs1, 01 PC, 10 zero.
- ALUSrcBE  out  1  0 rs2, 1 ImmExt.
- PCSrcE  out  1  redirect fetch.
- PCTargetSrcE  out  1  0 PC+Imm, 1 ALU result (JALR).
- ResultSrcE0  out  1  load-in-E flag for hazard unit.
- RegWriteE, RegWriteM, RegWriteW  out  1  register-write enable per stage.
- MemWriteM  out  1  store enable.
- funct3M  out  3  access size and sign for the load/store unit.
- ResultSrcW  out  2  00 ALU, 01 Mem, 10 PC+4.
- IllegalE  out  1  registered IllegalD, used for trap.

Behaviour:
- Decode (combinational, D):
  - lw 0000011: RegW=1, ImmI, B=imm, ResultSrc=01, ALUOp=00.
  - sw 0100011: MemW=1, ImmS, B=imm, ALUOp=00.
  - R 0110011: RegW=1, ALUOp=10.
  - I-ALU 0010011: RegW=1, ImmI, B=imm, ALUOp=10.
  - branch 1100011: Branch=1, ImmB, ALUOp=01.
  - jal 1101111: RegW=1, Jump=1, ImmJ, ResultSrc=10.
  - jalr 1100111 (funct3=000 only): RegW=1, Jump=1, Jalr=1, ImmI, B=imm, ALUOp=00, ResultSrc=10.
  - lui 0110111: RegW=1, ImmU, A=zero, B=imm, add.
  - auipc 0010111: RegW=1, ImmU, A=PC, B=imm, add.
- Load/store funct3:
  - lw and sw accept all funct3; funct3M is passed through for access size and sign.
  - Load/store funct3 legality is checked in M, not here.
- ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- ALUOp mapping:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3: 000 add (sub if R-type and f7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by f7b5, 110 or, 111 and.
- IllegalD: asserted for any unlisted opcode, any parameter-disabled encoding, and branch funct3 010/011.
- Illegal suppression: when IllegalD=1, all write/branch/jump controls entering D/E are forced to 0; IllegalE=1 travels with the bubble.
- D/E register update, priority order:
  1. reset: all fields 0.
  2. Hold: retain.
  3. FlushE: all fields 0, including IllegalE.
  4. Otherwise: load decoded values.
- Hold and FlushE together: Hold wins and the flush is not latched; the hazard unit must reassert FlushE.
- E/M and M/W registers: reset → 0; Hold → retain; otherwise shift forward. No flush on these registers.
- Branch resolution (combinational in E), taken condition by funct3E:
  - beq: ZeroE.
  - bne: !ZeroE.
  - blt: LtE.
  - bge: !LtE.
  - bltu: LtuE.
  - bgeu: !LtuE.
- Redirect: PCSrcE = (BranchE & taken) | JumpE; PCTargetSrcE = JalrE.
- PCSrcE is gated to 0 while Hold=1, so no double redirect occurs.
- Latency: control reaches E, M, W at 1, 2 and 3 clocks after D, plus one clock per Hold cycle.
- Reset value of every registered output is 0; PCSrcE is 0 during and after reset until a valid branch or jump reaches E.
- Reset mid-operation clears all in-flight control on the next edge.

Test Plan:
- reset=1 for 2 cycles with R-type on opD → all E/M/W outputs 0, PCSrcE=0. Release reset → RegWriteE=1 next cycle, RegWriteW=1 three cycles later.
- sub (op 0110011, f3 000, f7b5 1) → ALUControlE=0001. sra (f3 101, f7b5 1) → 1001. sltu → 0110.
- Branch sweep, funct3 001 (bne) with ZeroE=0 → PCSrcE=1; with ZeroE=1 → 0. bgeu with LtuE=1 → 0. EN_FULL_BRANCH=0 and blt in D → IllegalD=1, next cycle PCSrcE=0, IllegalE=1.
- jalr (1100111, f3 000) → ImmSrcD=000; in E: PCSrcE=1, PCTargetSrcE=1; in W: ResultSrcW=10. lui → ALUSrcAE=10, ALUSrcBE=1, ImmSrcD=100.
- lw in D with FlushE=1 → E fields 0, RegWriteE=0, ResultSrcE0=0. lw in D with FlushE=1 and Hold=1 → E retains prior contents.
- Hold held 3 cycles with sw in E → MemWriteM appears only after Hold drops, exactly once. Taken beq in E during Hold → PCSrcE=0 until release.
